// File: rtl/hms_timer.sv
// hms_timer: BCD hours:minutes:seconds timekeeper with a built-in prescaler,
// up/down counting, a range-checked synchronous preset load and optional
// stop-at-zero behaviour when counting down.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   en         in   count enable, gates the prescaler
//   up_down    in   1 = count up, 0 = count down
//   load       in   single-cycle preset request
//   load_time  in   BCD preset {hh, mm, ss}, 4 bits per digit
//   sec_units, sec_tens, min_units, min_tens, hour_units, hour_tens  out  BCD digits
//   sec_tick   out  pulse in the cycle after each step that changed the digits
//   rollover   out  pulse on wrap in either direction
//   done       out  sticky: count-down reached zero (STOP_AT_ZERO=1 only)
//   load_err   out  pulse: preset was out of range and rejected
// All outputs are registered.
`timescale 1ns/1ps

module hms_timer #(
  parameter int TICK_DIV     = 1,
  parameter int HOURS_MAX    = 24,
  parameter int STOP_AT_ZERO = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        up_down,
  input  logic        load,
  input  logic [23:0] load_time,
  output logic [3:0]  sec_units,
  output logic [2:0]  sec_tens,
  output logic [3:0]  min_units,
  output logic [2:0]  min_tens,
  output logic [3:0]  hour_units,
  output logic [1:0]  hour_tens,
  output logic        sec_tick,
  output logic        rollover,
  output logic        done,
  output logic        load_err
);

  localparam int              PRE_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [4:0]      HOUR_LAST = 5'(HOURS_MAX - 1);

  // State
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [3:0]       su_q, su_d;
  logic [2:0]       st_q, st_d;
  logic [3:0]       mu_q, mu_d;
  logic [2:0]       mt_q, mt_d;
  logic [4:0]       hour_q, hour_d;     // binary hour count
  logic [3:0]       hu_q, hu_d;         // registered hour digits
  logic [1:0]       ht_q, ht_d;
  logic             sec_tick_q, sec_tick_d;
  logic             rollover_q, rollover_d;
  logic             done_q, done_d;
  logic             load_err_q, load_err_d;

  // Preset decode
  logic [3:0] l_su, l_st, l_mu, l_mt, l_hu, l_ht;
  logic [7:0] l_hour_bin;
  logic       load_ok;
  logic       step;
  logic       at_max, at_zero, at_one;

  always_comb begin
    l_su       = load_time[3:0];
    l_st       = load_time[7:4];
    l_mu       = load_time[11:8];
    l_mt       = load_time[15:12];
    l_hu       = load_time[19:16];
    l_ht       = load_time[23:20];
    l_hour_bin = 8'(l_ht) * 8'd10 + 8'(l_hu);
    load_ok    = (l_su <= 4'd9) && (l_mu <= 4'd9) && (l_hu <= 4'd9) &&
                 (l_st <= 4'd5) && (l_mt <= 4'd5) &&
                 (l_hour_bin < 8'(HOURS_MAX));
  end

  assign step    = en && (pre_q == PRE_LAST);
  assign at_max  = (su_q == 4'd9) && (st_q == 3'd5) && (mu_q == 4'd9) &&
                   (mt_q == 3'd5) && (hour_q == HOUR_LAST);
  assign at_zero = (su_q == 4'd0) && (st_q == 3'd0) && (mu_q == 4'd0) &&
                   (mt_q == 3'd0) && (hour_q == 5'd0);
  assign at_one  = (su_q == 4'd1) && (st_q == 3'd0) && (mu_q == 4'd0) &&
                   (mt_q == 3'd0) && (hour_q == 5'd0);

  always_comb begin
    pre_d      = pre_q;
    su_d       = su_q;
    st_d       = st_q;
    mu_d       = mu_q;
    mt_d       = mt_q;
    hour_d     = hour_q;
    sec_tick_d = 1'b0;
    rollover_d = 1'b0;
    load_err_d = 1'b0;
    // Sampling up_down=1 at any edge clears the sticky flag.
    done_d     = done_q & ~up_down;

    if (load) begin
      // Any step coinciding with a load is discarded, valid or not.
      if (load_ok) begin
        su_d   = l_su;
        st_d   = 3'(l_st);
        mu_d   = l_mu;
        mt_d   = 3'(l_mt);
        hour_d = 5'(l_hour_bin);
        pre_d  = '0;
        done_d = 1'b0;
      end else begin
        load_err_d = 1'b1;
      end
    end else begin
      if (en) begin
        pre_d = step ? '0 : pre_q + PRE_W'(1);
      end
      if (step) begin
        if (up_down) begin
          sec_tick_d = 1'b1;
          rollover_d = at_max;
          if (su_q != 4'd9) su_d = su_q + 4'd1;
          else begin
            su_d = 4'd0;
            if (st_q != 3'd5) st_d = st_q + 3'd1;
            else begin
              st_d = 3'd0;
              if (mu_q != 4'd9) mu_d = mu_q + 4'd1;
              else begin
                mu_d = 4'd0;
                if (mt_q != 3'd5) mt_d = mt_q + 3'd1;
                else begin
                  mt_d   = 3'd0;
                  hour_d = (hour_q == HOUR_LAST) ? 5'd0 : hour_q + 5'd1;
                end
              end
            end
          end
        end else if (at_zero && (STOP_AT_ZERO != 0)) begin
          // Parked at zero: digits hold, no tick; a down step here means
          // the count-down is at its end, so the flag is (re)asserted.
          done_d = 1'b1;
        end else begin
          sec_tick_d = 1'b1;
          rollover_d = at_zero;
          if (at_one && (STOP_AT_ZERO != 0)) done_d = 1'b1;
          if (su_q != 4'd0) su_d = su_q - 4'd1;
          else begin
            su_d = 4'd9;
            if (st_q != 3'd0) st_d = st_q - 3'd1;
            else begin
              st_d = 3'd5;
              if (mu_q != 4'd0) mu_d = mu_q - 4'd1;
              else begin
                mu_d = 4'd9;
                if (mt_q != 3'd0) mt_d = mt_q - 3'd1;
                else begin
                  mt_d   = 3'd5;
                  hour_d = (hour_q == 5'd0) ? HOUR_LAST : hour_q - 5'd1;
                end
              end
            end
          end
        end
      end
    end
  end

  // Binary hour count to tens/units; the hour count never exceeds 23.
  always_comb begin
    if (hour_d >= 5'd20) begin
      ht_d = 2'd2;
      hu_d = 4'(hour_d - 5'd20);
    end else if (hour_d >= 5'd10) begin
      ht_d = 2'd1;
      hu_d = 4'(hour_d - 5'd10);
    end else begin
      ht_d = 2'd0;
      hu_d = 4'(hour_d);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_q      <= '0;
      su_q       <= '0;
      st_q       <= '0;
      mu_q       <= '0;
      mt_q       <= '0;
      hour_q     <= '0;
      hu_q       <= '0;
      ht_q       <= '0;
      sec_tick_q <= 1'b0;
      rollover_q <= 1'b0;
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      pre_q      <= pre_d;
      su_q       <= su_d;
      st_q       <= st_d;
      mu_q       <= mu_d;
      mt_q       <= mt_d;
      hour_q     <= hour_d;
      hu_q       <= hu_d;
      ht_q       <= ht_d;
      sec_tick_q <= sec_tick_d;
      rollover_q <= rollover_d;
      done_q     <= done_d;
      load_err_q <= load_err_d;
    end
  end

  assign sec_units  = su_q;
  assign sec_tens   = st_q;
  assign min_units  = mu_q;
  assign min_tens   = mt_q;
  assign hour_units = hu_q;
  assign hour_tens  = ht_q;
  assign sec_tick   = sec_tick_q;
  assign rollover   = rollover_q;
  assign done       = done_q;
  assign load_err   = load_err_q;

endmodule

// File: tb/tb_hms_timer.sv
// Testbench for hms_timer: four instances with different parameters share one
// directed stimulus stream. A time-in-seconds model per instance is checked
// against every instance on every falling edge; hand-computed literals pin
// the key points of each scenario.
`timescale 1ns/1ps

module tb_hms_timer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic        up_down = 1'b1;
  logic        load = 1'b0;
  logic [23:0] load_time = 24'h0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Observed outputs per instance: {ht,hu,mt,mu,st,su,tick,roll,done,err}
  logic [3:0][23:0] obs;

  // k0: TICK_DIV=4 H=24 stop; k1: 1/24/stop; k2: 1/12/wrap; k3: 1/24/wrap
  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    logic [3:0] su, mu, hu;
    logic [2:0] st, mt;
    logic [1:0] ht;
    logic       tk, ro, dn, le;
    hms_timer #(
      .TICK_DIV    (gi == 0 ? 4 : 1),
      .HOURS_MAX   (gi == 2 ? 12 : 24),
      .STOP_AT_ZERO(gi < 2 ? 1 : 0)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .up_down   (up_down),
      .load      (load),
      .load_time (load_time),
      .sec_units (su),
      .sec_tens  (st),
      .min_units (mu),
      .min_tens  (mt),
      .hour_units(hu),
      .hour_tens (ht),
      .sec_tick  (tk),
      .rollover  (ro),
      .done      (dn),
      .load_err  (le)
    );
    assign obs[gi] = {ht, hu, mt, mu, st, su, tk, ro, dn, le};
  end

  // ---------------- model ----------------
  function automatic int td(int k); return (k == 0) ? 4 : 1; endfunction
  function automatic int hm(int k); return (k == 2) ? 12 : 24; endfunction
  function automatic bit sz(int k); return k < 2; endfunction

  int m_t[4]   = '{0, 0, 0, 0};   // time of day in seconds
  int m_pre[4] = '{0, 0, 0, 0};
  bit m_done[4], m_tick[4], m_roll[4], m_err[4];

  task automatic model_step(int k);
    int  tmax, h, mi, s;
    bit  stp;
    tmax = hm(k) * 3600 - 1;
    stp  = en && (m_pre[k] == td(k) - 1);
    m_tick[k] = 0;
    m_roll[k] = 0;
    m_err[k]  = 0;
    if (up_down) m_done[k] = 0;
    if (load) begin
      h  = int'(load_time[23:20]) * 10 + int'(load_time[19:16]);
      mi = int'(load_time[15:12]) * 10 + int'(load_time[11:8]);
      s  = int'(load_time[7:4]) * 10 + int'(load_time[3:0]);
      if (load_time[19:16] <= 9 && load_time[11:8] <= 9 && load_time[3:0] <= 9 &&
          load_time[15:12] <= 5 && load_time[7:4] <= 5 && h < hm(k)) begin
        m_t[k]    = h * 3600 + mi * 60 + s;
        m_pre[k]  = 0;
        m_done[k] = 0;
      end else begin
        m_err[k] = 1;
      end
    end else begin
      if (en) m_pre[k] = stp ? 0 : m_pre[k] + 1;
      if (stp) begin
        if (up_down) begin
          m_tick[k] = 1;
          if (m_t[k] == tmax) begin m_t[k] = 0; m_roll[k] = 1; end
          else m_t[k] = m_t[k] + 1;
        end else if (m_t[k] == 0) begin
          if (sz(k)) m_done[k] = 1;
          else begin m_t[k] = tmax; m_roll[k] = 1; m_tick[k] = 1; end
        end else begin
          m_tick[k] = 1;
          m_t[k] = m_t[k] - 1;
          if (m_t[k] == 0 && sz(k)) m_done[k] = 1;
        end
      end
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 4; k++) begin
        m_t[k] = 0; m_pre[k] = 0; m_done[k] = 0;
        m_tick[k] = 0; m_roll[k] = 0; m_err[k] = 0;
      end
    end else begin
      for (int k = 0; k < 4; k++) model_step(k);
    end
  end

  function automatic logic [23:0] expv(int k);
    int h, mi, s;
    h  = m_t[k] / 3600;
    mi = (m_t[k] / 60) % 60;
    s  = m_t[k] % 60;
    return {2'(h / 10), 4'(h % 10), 3'(mi / 10), 4'(mi % 10), 3'(s / 10), 4'(s % 10),
            m_tick[k], m_roll[k], m_done[k], m_err[k]};
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (obs[k] !== expv(k)) begin
        n_fail++;
        $display("FAIL model_k%0d at %0t: got=%h expected=%h", k, $time, obs[k], expv(k));
      end
    end
  end

  // ---------------- literal checks ----------------
  function automatic logic [23:0] lit(logic [23:0] hms, logic tk, logic ro, logic dn, logic le);
    return {hms[21:20], hms[19:16], hms[14:12], hms[11:8], hms[6:4], hms[3:0], tk, ro, dn, le};
  endfunction

  task automatic chk(string name, logic [23:0] got, logic [23:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end else begin
      $display("[TB] ok %s = %h", name, got);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(logic [23:0] v);
    load = 1'b1;
    load_time = v;
    cyc(1);
    load = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b0;
    cyc(2);
    chk("reset_k0", obs[0], 24'h0);
    chk("reset_k2", obs[2], 24'h0);

    // 1: prescaler, TICK_DIV=4 on k0
    reset = 1'b1; en = 1'b1; up_down = 1'b1;
    cyc(3); chk("pre_edge3",  obs[0], lit(24'h000000, 0, 0, 0, 0));
    cyc(1); chk("pre_edge4",  obs[0], lit(24'h000001, 1, 0, 0, 0));
    cyc(1); chk("pre_edge5",  obs[0], lit(24'h000001, 0, 0, 0, 0));
    cyc(3); chk("pre_edge8",  obs[0], lit(24'h000002, 1, 0, 0, 0));
    cyc(2); en = 1'b0;
    cyc(3); en = 1'b1;
    chk("pre_frozen", obs[0], lit(24'h000002, 0, 0, 0, 0));
    cyc(1); chk("pre_delay6", obs[0], lit(24'h000002, 0, 0, 0, 0));
    cyc(1); chk("pre_delay7", obs[0], lit(24'h000003, 1, 0, 0, 0));

    // 2: 24h wrap on k1
    do_load(24'h235958);
    chk("load_235958", obs[1], lit(24'h235958, 0, 0, 0, 0));
    chk("h12_err_23",  {23'd0, obs[2][0]}, 24'd1);
    cyc(1); chk("up_235959", obs[1], lit(24'h235959, 1, 0, 0, 0));
    cyc(1); chk("up_wrap",   obs[1], lit(24'h000000, 1, 1, 0, 0));
    cyc(1); chk("up_000001", obs[1], lit(24'h000001, 1, 0, 0, 0));

    // 3: HOURS_MAX=12 on k2
    do_load(24'h120000);
    chk("h12_err_12", {23'd0, obs[2][0]}, 24'd1);
    do_load(24'h115959);
    chk("h12_load",   obs[2], lit(24'h115959, 0, 0, 0, 0));
    cyc(1); chk("h12_wrap", obs[2], lit(24'h000000, 1, 1, 0, 0));

    // 4: count down, stop at zero on k1
    up_down = 1'b0;
    do_load(24'h000100);
    chk("dn_load",   obs[1], lit(24'h000100, 0, 0, 0, 0));
    cyc(1);  chk("dn_000059", obs[1], lit(24'h000059, 1, 0, 0, 0));
    cyc(58); chk("dn_000001", obs[1], lit(24'h000001, 1, 0, 0, 0));
    cyc(1);  chk("dn_zero",   obs[1], lit(24'h000000, 1, 0, 1, 0));
    cyc(1);  chk("dn_hold",   obs[1], lit(24'h000000, 0, 0, 1, 0));
    up_down = 1'b1;
    cyc(1);  chk("dn_resume", obs[1], lit(24'h000001, 1, 0, 0, 0));

    // 5: count down with wrap on k3, bad tens digit
    up_down = 1'b0;
    do_load(24'h000000);
    chk("wr_load", obs[3], lit(24'h000000, 0, 0, 0, 0));
    cyc(1); chk("wr_wrap", obs[3], lit(24'h235959, 1, 1, 0, 0));
    do_load(24'h006000);
    chk("bad_tens", obs[3], lit(24'h235959, 0, 0, 0, 1));

    // 6: load beats step; async reset mid-cycle
    up_down = 1'b1;
    do_load(24'h010203);
    chk("ld_vs_step", obs[1], lit(24'h010203, 0, 0, 0, 0));
    cyc(1); chk("after_ld", obs[1], lit(24'h010204, 1, 0, 0, 0));
    #3 reset = 1'b0;
    #1 chk("async_rst_k1", obs[1], 24'h0);
    chk("async_rst_k3", obs[3], 24'h0);
    cyc(1);
    reset = 1'b1;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
